// File: rtl/seven_segment_reader.sv
// Reads back multiplexed active-low seven-segment samples, filters each digit for
// stability and reports committed changes as BCD values on an event stream.
module seven_segment_reader #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        seg_valid,
    input  logic [2:0]  seg_digit,
    input  logic [6:0]  seg_in,
    input  logic        illegal_clr,
    output logic [31:0] bcd_out,
    output logic [7:0]  digit_on,
    output logic [7:0]  illegal,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [2:0]  evt_digit,
    output logic [3:0]  evt_bcd,
    output logic        evt_blank
);

    localparam logic [3:0] STABLE = 4'(STABLE_SAMPLES);
    localparam logic [6:0] BLANK  = 7'h7F;

    logic [6:0] committed [8];
    logic [6:0] cand      [8];
    logic [3:0] cnt       [8];
    logic [7:0] pending;

    logic [3:0] dec_bcd;
    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] cur_cnt;
    logic [3:0] new_cnt;
    logic       commit;
    logic       commit_illegal;
    logic       load;
    logic       found;
    logic [2:0] pick;
    logic [7:0] pending_next;
    logic [7:0] illegal_next;

    // Active-low segments: bit 0 is segment a, bit 6 is segment g.
    always_comb begin
        dec_bcd   = 4'd0;
        dec_legal = 1'b1;
        case (seg_in)
            7'b1000000: dec_bcd = 4'd0;
            7'b1111001: dec_bcd = 4'd1;
            7'b0100100: dec_bcd = 4'd2;
            7'b0110000: dec_bcd = 4'd3;
            7'b0011001: dec_bcd = 4'd4;
            7'b0010010: dec_bcd = 4'd5;
            7'b0000010: dec_bcd = 4'd6;
            7'b1111000: dec_bcd = 4'd7;
            7'b0000000: dec_bcd = 4'd8;
            7'b0010000: dec_bcd = 4'd9;
            default:    dec_legal = 1'b0;
        endcase
        dec_blank = (seg_in == BLANK);
    end

    // When the count reaches the threshold the candidate always equals seg_in,
    // so seg_in is the pattern that commits.
    always_comb begin
        cur_cnt = cnt[seg_digit];
        if (seg_in != cand[seg_digit]) begin
            new_cnt = 4'd1;
        end else if (cur_cnt >= STABLE) begin
            new_cnt = STABLE;
        end else begin
            new_cnt = cur_cnt + 4'd1;
        end
        commit         = seg_valid && (new_cnt == STABLE) && (seg_in != committed[seg_digit]);
        commit_illegal = commit && !dec_legal && !dec_blank;
    end

    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
    end

    // Handshake: an event transfers on a cycle where evt_valid && evt_ready; while
    // evt_valid is high and evt_ready low the evt_* fields do not change, and a new
    // event may be loaded on the same edge that accepts the previous one.
    assign load = !evt_valid || evt_ready;

    // A commit of the digit being loaded re-arms its pending bit for a later event.
    always_comb begin
        pending_next = pending;
        if (load && found) begin
            pending_next[pick] = 1'b0;
        end
        if (commit && !commit_illegal) begin
            pending_next[seg_digit] = 1'b1;
        end
        illegal_next = illegal & ~{8{illegal_clr}};
        if (commit_illegal) begin
            illegal_next[seg_digit] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                committed[i] <= BLANK;
                cand[i]      <= BLANK;
                cnt[i]       <= 4'd0;
            end
            pending   <= 8'd0;
            bcd_out   <= 32'd0;
            digit_on  <= 8'd0;
            illegal   <= 8'd0;
            evt_valid <= 1'b0;
            evt_digit <= 3'd0;
            evt_bcd   <= 4'd0;
            evt_blank <= 1'b0;
        end else begin
            if (seg_valid) begin
                cand[seg_digit] <= seg_in;
                cnt[seg_digit]  <= new_cnt;
            end
            if (commit) begin
                committed[seg_digit] <= seg_in;
                if (dec_legal) begin
                    bcd_out[{seg_digit, 2'b00} +: 4] <= dec_bcd;
                    digit_on[seg_digit]              <= 1'b1;
                end else if (dec_blank) begin
                    digit_on[seg_digit] <= 1'b0;
                end
            end
            illegal <= illegal_next;
            pending <= pending_next;
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_digit <= pick;
                    evt_bcd   <= bcd_out[{pick, 2'b00} +: 4];
                    evt_blank <= !digit_on[pick];
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scenarios plus random traffic, all
// compared against a per-digit behavioural model of the display reader.
module tb_seven_segment_reader;

    localparam int S = 3;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] BAD_A = 7'b0101010;
    localparam logic [6:0] BAD_B = 7'b0101011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        seg_valid = 1'b0;
    logic [2:0]  seg_digit = 3'd0;
    logic [6:0]  seg_in = BLANK;
    logic        illegal_clr = 1'b0;
    logic [31:0] bcd_out;
    logic [7:0]  digit_on;
    logic [7:0]  illegal;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_digit;
    logic [3:0]  evt_bcd;
    logic        evt_blank;

    seven_segment_reader #(.STABLE_SAMPLES(S)) dut (
        .clock(clock), .reset(reset), .seg_valid(seg_valid), .seg_digit(seg_digit),
        .seg_in(seg_in), .illegal_clr(illegal_clr), .bcd_out(bcd_out),
        .digit_on(digit_on), .illegal(illegal), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_digit(evt_digit), .evt_bcd(evt_bcd),
        .evt_blank(evt_blank)
    );

    always #5 clock = ~clock;

    logic [56:0] obs_vec;
    assign obs_vec = {bcd_out, digit_on, illegal, evt_valid, evt_digit, evt_bcd, evt_blank};

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // Reference model: what the display currently shows per digit and a set of
    // digits owing a report.
    logic [6:0] m_cand [8];
    int         m_cnt  [8];
    logic [6:0] m_shown[8];
    int         m_val  [8];
    bit         m_on   [8];
    bit         m_ill  [8];
    bit         m_owe  [8];
    bit         m_ev;
    int         m_evd, m_evb;
    bit         m_evk;

    int         acc_count = 0;
    int         last_d, last_b;
    bit         last_k;

    function automatic int decode_m(logic [6:0] p);
        if (p == BLANK) return 10;
        for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [56:0] exp_vec();
        logic [31:0] b;
        logic [7:0]  on, il;
        for (int d = 0; d < 8; d++) begin
            b[4*d +: 4] = 4'(m_val[d]);
            on[d] = m_on[d];
            il[d] = m_ill[d];
        end
        return {b, on, il, m_ev, 3'(m_evd), 4'(m_evb), m_evk};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 8; d++) begin
            m_cand[d] = BLANK; m_cnt[d] = 0; m_shown[d] = BLANK;
            m_val[d] = 0; m_on[d] = 0; m_ill[d] = 0; m_owe[d] = 0;
        end
        m_ev = 0; m_evd = 0; m_evb = 0; m_evk = 0;
    endtask

    task automatic model_edge(bit v, int d, logic [6:0] s, bit clr, bit rdy);
        int p = -1;
        int k;
        if (!m_ev || rdy) begin
            for (int i = 7; i >= 0; i--) if (m_owe[i]) p = i;
            m_ev = (p >= 0);
            if (p >= 0) begin
                m_evd = p; m_evb = m_val[p]; m_evk = !m_on[p]; m_owe[p] = 0;
            end
        end
        if (clr) for (int i = 0; i < 8; i++) m_ill[i] = 0;
        if (v) begin
            if (s == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > S) ? S : m_cnt[d] + 1;
            else begin m_cand[d] = s; m_cnt[d] = 1; end
            if (m_cnt[d] == S && s != m_shown[d]) begin
                m_shown[d] = s;
                k = decode_m(s);
                if (k < 0) m_ill[d] = 1;
                else if (k == 10) begin m_on[d] = 0; m_owe[d] = 1; end
                else begin m_val[d] = k; m_on[d] = 1; m_owe[d] = 1; end
            end
        end
    endtask

    // Drives one cycle of inputs, logs any accepted event, advances the model.
    task automatic step(bit v, int d, logic [6:0] s, bit clr, bit rdy, bit rst);
        reset = rst; seg_valid = v; seg_digit = 3'(d); seg_in = s;
        illegal_clr = clr; evt_ready = rdy;
        #1;
        if (!rst && evt_valid && rdy) begin
            acc_count++; last_d = evt_digit; last_b = evt_bcd; last_k = evt_blank;
        end
        @(posedge clock);
        if (rst) model_reset(); else model_edge(v, d, s, clr, rdy);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        step(0, 0, BLANK, 0, 0, 1);
        step(0, 0, BLANK, 0, 0, 1);
        vectors++; if (obs_vec !== 57'd0) begin miscompares++; $display("FAIL reset_zero got %h exp 0", obs_vec); end
        vectors++; if (obs_vec !== exp_vec()) begin miscompares++; $display("FAIL reset_model got %h exp %h", obs_vec, exp_vec()); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) step(1, 2, pat_tab[2], 0, 0, 0);
        vectors++; if (digit_on[2] !== 1'b1) begin miscompares++; $display("FAIL basic_on got %b exp 1", digit_on[2]); end
        vectors++; if (bcd_out[11:8] !== 4'd2) begin miscompares++; $display("FAIL basic_bcd got %0d exp 2", bcd_out[11:8]); end
        step(0, 0, BLANK, 0, 0, 0);
        vectors++; if ({evt_valid, evt_digit, evt_bcd, evt_blank} !== {1'b1, 3'd2, 4'd2, 1'b0}) begin
            miscompares++; $display("FAIL basic_evt got v%b d%0d b%0d k%b exp v1 d2 b2 k0", evt_valid, evt_digit, evt_bcd, evt_blank); end
        vectors++; if (obs_vec !== exp_vec()) begin miscompares++; $display("FAIL basic_model got %h exp %h", obs_vec, exp_vec()); end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) step(1, 6, pat_tab[9], 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, pat_tab[8], 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, BLANK, 0, 0, 0);
            vectors++; if ({evt_valid, evt_digit} !== {1'b1, 3'd2}) begin miscompares++; $display("FAIL prio_hold2 got v%b d%0d exp v1 d2", evt_valid, evt_digit); end
        end
        step(0, 0, BLANK, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({evt_valid, evt_digit, evt_bcd} !== {1'b1, 3'd1, 4'd8}) begin
                miscompares++; $display("FAIL prio_d1 got v%b d%0d b%0d exp v1 d1 b8", evt_valid, evt_digit, evt_bcd); end
            step(0, 0, BLANK, 0, (i == 3), 0);
        end
        vectors++; if ({evt_valid, evt_digit, evt_bcd, evt_blank} !== {1'b1, 3'd6, 4'd9, 1'b0}) begin
            miscompares++; $display("FAIL prio_d6 got v%b d%0d b%0d exp v1 d6 b9", evt_valid, evt_digit, evt_bcd); end
        step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (obs_vec !== exp_vec()) begin miscompares++; $display("FAIL prio_model got %h exp %h", obs_vec, exp_vec()); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL prio_drain got %b exp 0", evt_valid); end
    endtask

    task automatic test_glitch();
        int start = acc_count;
        logic [6:0] seq [5];
        seq = '{pat_tab[5], pat_tab[5], pat_tab[7], pat_tab[5], pat_tab[5]};
        for (int i = 0; i < 5; i++) step(1, 5, seq[i], 0, 1, 0);
        step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (digit_on[5] !== 1'b0 || acc_count != start) begin
            miscompares++; $display("FAIL glitch_early got on%b ev%0d exp on0 ev0", digit_on[5], acc_count - start); end
        step(1, 5, pat_tab[5], 0, 1, 0);
        vectors++; if ({digit_on[5], bcd_out[23:20]} !== {1'b1, 4'd5}) begin
            miscompares++; $display("FAIL glitch_commit got on%b b%0d exp on1 b5", digit_on[5], bcd_out[23:20]); end
        for (int i = 0; i < 3; i++) step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (acc_count - start != 1 || last_d != 5 || last_b != 5) begin
            miscompares++; $display("FAIL glitch_events got n%0d d%0d b%0d exp n1 d5 b5", acc_count - start, last_d, last_b); end
    endtask

    task automatic test_saturate();
        int start = acc_count;
        for (int i = 0; i < 20; i++) step(1, 0, pat_tab[4], 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (acc_count - start != 1 || last_d != 0 || last_b != 4) begin
            miscompares++; $display("FAIL sat_once got n%0d d%0d b%0d exp n1 d0 b4", acc_count - start, last_d, last_b); end
        for (int i = 0; i < 3; i++) step(1, 0, BLANK, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (acc_count - start != 2 || last_k != 1'b1 || last_b != 4 || digit_on[0] !== 1'b0) begin
            miscompares++; $display("FAIL sat_blank got n%0d k%b b%0d on%b exp n2 k1 b4 on0", acc_count - start, last_k, last_b, digit_on[0]); end
        vectors++; if (obs_vec !== exp_vec()) begin miscompares++; $display("FAIL sat_model got %h exp %h", obs_vec, exp_vec()); end
    endtask

    task automatic test_illegal();
        int start = acc_count;
        for (int i = 0; i < 3; i++) step(1, 7, BAD_A, 0, 1, 0);
        vectors++; if ({illegal[7], digit_on[7]} !== 2'b10) begin
            miscompares++; $display("FAIL ill_set got ill%b on%b exp ill1 on0", illegal[7], digit_on[7]); end
        for (int i = 0; i < 2; i++) step(0, 0, BLANK, 0, 1, 0);
        vectors++; if (acc_count != start) begin miscompares++; $display("FAIL ill_noevt got %0d exp 0", acc_count - start); end
        step(0, 0, BLANK, 1, 1, 0);
        vectors++; if (illegal !== 8'h00) begin miscompares++; $display("FAIL ill_clr got %h exp 00", illegal); end
        step(1, 7, BAD_B, 0, 1, 0);
        step(1, 7, BAD_B, 0, 1, 0);
        step(1, 7, BAD_B, 1, 1, 0);
        vectors++; if (illegal !== 8'h80) begin miscompares++; $display("FAIL ill_race got %h exp 80", illegal); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 3, pat_tab[3], 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4, pat_tab[6], 0, 0, 0);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre got %b exp 1", evt_valid); end
        step(0, 0, BLANK, 0, 0, 1);
        vectors++; if (obs_vec !== 57'd0) begin miscompares++; $display("FAIL rmid_zero got %h exp 0", obs_vec); end
        step(0, 0, BLANK, 0, 0, 0);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_drop got %b exp 0", evt_valid); end
        for (int i = 0; i < 3; i++) step(1, 3, pat_tab[3], 0, 0, 0);
        step(0, 0, BLANK, 0, 0, 0);
        vectors++; if ({digit_on[3], bcd_out[15:12], evt_valid, evt_digit} !== {1'b1, 4'd3, 1'b1, 3'd3}) begin
            miscompares++; $display("FAIL rmid_again got on%b b%0d v%b d%0d exp on1 b3 v1 d3", digit_on[3], bcd_out[15:12], evt_valid, evt_digit); end
    endtask

    function automatic logic [6:0] rand_pat();
        int r = $urandom_range(0, 11);
        if (r < 10) return pat_tab[r];
        return (r == 10) ? BLANK : BAD_A;
    endfunction

    task automatic test_random();
        logic [6:0] intent [8];
        for (int d = 0; d < 8; d++) intent[d] = BLANK;
        for (int n = 0; n < 600; n++) begin
            int  d = $urandom_range(0, 7);
            bit  v = ($urandom_range(0, 9) < 7);
            bit  rst = ($urandom_range(0, 249) == 0);
            logic [6:0] s;
            if ($urandom_range(0, 9) == 0) intent[d] = rand_pat();
            s = ($urandom_range(0, 7) == 0) ? rand_pat() : intent[d];
            step(v, d, s, ($urandom_range(0, 29) == 0), $urandom_range(0, 1), rst);
            vectors++; if (obs_vec !== exp_vec()) begin
                miscompares++; $display("FAIL random_%0d got %h exp %h", n, obs_vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_glitch();
        test_saturate();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
